// File: rtl/ahb5_pkg.sv
// Shared AHB5 definitions: transfer and size encodings, response codes,
// slave FSM states and the byte-lane decode used by the memory slave.
package ahb5_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    localparam int unsigned WAIT_W = 4;

    // Little-endian lane enables; anything wider than a half counts as a word.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'hF;
        if (size == HSIZE_BYTE) begin
            be = 4'b0001 << lane;
        end else if (size == HSIZE_HALF) begin
            be = lane[1] ? 4'b1100 : 4'b0011;
        end
        return be;
    endfunction

endpackage

// File: rtl/ahb5_slv_mem_array.sv
// Word-organised storage for the AHB5 memory slave.
// Ports: clk; we/be/waddr/wdata = one write port with per-byte enables;
//        raddr/rdata_c = asynchronous read port. Contents are never reset.
module ahb5_slv_mem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata_c
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 memory slave with configurable wait states and pipelined transfers.
// Ports: Hclk/HResetn (sync, active-low); AHB address phase HSEL, HADDR,
//        HTRANS, HWRITE, HSIZE, HBURST (ignored), HREADY; data phase HWDATA;
//        responses HREADYOUT, HRESP, HRDATA.
// Build option: define AHB5_SLV_ERR_EN to return two-cycle ERROR responses for
// out-of-range, oversize or misaligned transfers; otherwise addresses wrap and
// HRESP stays OKAY.
module ahb5_slave_mem #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        Hclk,
    input  logic        HResetn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    import ahb5_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] cnt;
    logic              accept_c, err_c, we_c, rd_load_c;
    logic              a_valid, a_write, a_err;
    logic [3:0]        a_be;
    logic [AW-1:0]     a_idx, rd_idx_c;
    logic [31:0]       mem_rdata_c, rd_word_c;
    logic              unused_inputs;

    assign unused_inputs = ^{HBURST, HTRANS[0], HADDR};

    // HREADYOUT gate keeps address changes during wait/error cycles out
    assign accept_c = HSEL & HREADY & HTRANS[1] & HREADYOUT;

`ifdef AHB5_SLV_ERR_EN
    logic range_err_c, size_err_c, align_err_c;
    assign range_err_c = (HADDR >> (AW + 2)) != 32'd0;
    assign size_err_c  = HSIZE > HSIZE_WORD;
    assign align_err_c = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                         ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign err_c = range_err_c | size_err_c | align_err_c;
`else
    assign err_c = 1'b0;
`endif

    // State register
    always_ff @(posedge Hclk) begin
        if (!HResetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; ST_IDLE and ST_ERR2 are the cycles that can take a new transfer
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (accept_c) begin
                    if (err_c)                state_nxt = ST_ERR1;
                    else if (WAIT_CYCLES > 0) state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: if (cnt == '0) state_nxt = ST_IDLE;
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response outputs decoded from the state register
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // Wait-state counter: loaded with N-1 so ST_WAIT lasts exactly N cycles
    always_ff @(posedge Hclk) begin
        if (!HResetn) begin
            cnt <= '0;
        end else if (accept_c && !err_c) begin
            cnt <= WAIT_LOAD;
        end else if ((state == ST_WAIT) && (cnt != '0)) begin
            cnt <= cnt - WAIT_W'(1);
        end
    end

    // Pending address phase; retired on every ready cycle
    always_ff @(posedge Hclk) begin
        if (!HResetn) begin
            a_valid <= 1'b0;
            a_write <= 1'b0;
            a_err   <= 1'b0;
            a_be    <= '0;
            a_idx   <= '0;
        end else if (HREADYOUT) begin
            a_valid <= accept_c;
            if (accept_c) begin
                a_write <= HWRITE;
                a_err   <= err_c;
                a_be    <= byte_enables(HSIZE, HADDR[1:0]);
                a_idx   <= HADDR[AW+1:2];
            end
        end
    end

    assign we_c = a_valid & a_write & ~a_err & HREADYOUT & HResetn;

    // Zero-wait reads load at capture; waited reads load on the last wait cycle
    always_comb begin
        rd_load_c = 1'b0;
        rd_idx_c  = HADDR[AW+1:2];
        if ((WAIT_CYCLES == 0) && accept_c && !HWRITE && !err_c) begin
            rd_load_c = 1'b1;
        end else if ((state == ST_WAIT) && (cnt == '0) && a_valid && !a_write) begin
            rd_load_c = 1'b1;
            rd_idx_c  = a_idx;
        end
    end

    // Forward lanes of a write committing on the same edge
    always_comb begin
        rd_word_c = mem_rdata_c;
        for (int b = 0; b < 4; b++) begin
            if (we_c && (a_idx == rd_idx_c) && a_be[b]) begin
                rd_word_c[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (!HResetn)       HRDATA <= '0;
        else if (rd_load_c) HRDATA <= rd_word_c;
    end

    ahb5_slv_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (Hclk),
        .we      (we_c),
        .be      (a_be),
        .waddr   (a_idx),
        .wdata   (HWDATA),
        .raddr   (rd_idx_c),
        .rdata_c (mem_rdata_c)
    );

endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Directed bench for ahb5_slave_mem: instance 0 runs zero wait states,
// instance 1 runs two wait states; both use DEPTH=1024.
module tb_ahb5_slave_mem;

    logic        clk;
    logic        hresetn   [2];
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    int checks = 0;
    int passed = 0;

    ahb5_slave_mem #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .Hclk(clk), .HResetn(hresetn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]),
        .HWDATA(hwdata[0]), .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]),
        .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb5_slave_mem #(.DEPTH(1024), .WAIT_CYCLES(2)) dut1 (
        .Hclk(clk), .HResetn(hresetn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]),
        .HWDATA(hwdata[1]), .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]),
        .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'd0;
        haddr[d]  = 32'h0;
        hwrite[d] = 1'b0;
        hsize[d]  = 3'd2;
        hburst[d] = 3'd0;
    endtask

    // Single non-pipelined transfer; called and returns at posedge+1
    task automatic do_xfer(input int d, input logic [31:0] addr, input logic wr,
                           input logic [2:0] size, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int waits,
                           output logic resp, output logic first_resp);
        int n;
        hsel[d]   = 1'b1;
        htrans[d] = 2'd2;
        haddr[d]  = addr;
        hwrite[d] = wr;
        hsize[d]  = size;
        hburst[d] = 3'd0;
        n = 0;
        @(negedge clk);
        while (!hreadyout[d] && n < 64) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        drive_idle(d);
        hwdata[d] = wdata;
        waits = 0;
        @(negedge clk);
        first_resp = hresp[d];
        while (!hreadyout[d] && waits < 64) begin
            waits++;
            @(negedge clk);
        end
        resp  = hresp[d];
        rdata = hrdata[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (hreadyout[d] !== 1'b1) $display("FAIL reset_hreadyout[%0d]: got %b expected 1", d, hreadyout[d]);
            else passed++;
            checks++;
            if (hresp[d] !== 1'b0) $display("FAIL reset_hresp[%0d]: got %b expected 0", d, hresp[d]);
            else passed++;
            checks++;
            if (hrdata[d] !== 32'h0) $display("FAIL reset_hrdata[%0d]: got %h expected 00000000", d, hrdata[d]);
            else passed++;
        end
    endtask

    // Pipelined write then read of the same word, zero wait states
    task automatic test_write_read();
        logic [31:0] rd;
        int w;
        logic rs, fr;
        hsel[0] = 1'b1; htrans[0] = 2'd2; haddr[0] = 32'h10; hwrite[0] = 1'b1; hsize[0] = 3'd2;
        @(posedge clk); #1;
        haddr[0] = 32'h10; hwrite[0] = 1'b0; hwdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (hreadyout[0] !== 1'b1) $display("FAIL wr_zero_wait: hreadyout %b expected 1", hreadyout[0]);
        else passed++;
        @(posedge clk); #1;
        drive_idle(0);
        @(negedge clk);
        checks++;
        if (hreadyout[0] !== 1'b1) $display("FAIL rd_zero_wait: hreadyout %b expected 1", hreadyout[0]);
        else passed++;
        checks++;
        if (hrdata[0] !== 32'hDEADBEEF) $display("FAIL rd_forward: got %h expected deadbeef", hrdata[0]);
        else passed++;
        @(posedge clk); #1;
        do_xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, w, rs, fr);
        checks++;
        if (rd !== 32'hDEADBEEF || w !== 0 || rs !== 1'b0)
            $display("FAIL rd_again: data %h waits %0d resp %b expected deadbeef 0 0", rd, w, rs);
        else passed++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        int w;
        logic rs, fr;
        do_xfer(0, 32'h10, 1'b1, 3'd2, 32'h11223344, rd, w, rs, fr);
        do_xfer(0, 32'h13, 1'b1, 3'd0, 32'hAA000000, rd, w, rs, fr);
        do_xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, w, rs, fr);
        checks++;
        if (rd !== 32'hAA223344) $display("FAIL byte_write: got %h expected aa223344", rd);
        else passed++;
        do_xfer(0, 32'h14, 1'b1, 3'd2, 32'h55667788, rd, w, rs, fr);
        do_xfer(0, 32'h16, 1'b1, 3'd1, 32'hBEEF0000, rd, w, rs, fr);
        checks++;
        if (rd !== 32'hAA223344) $display("FAIL hrdata_hold: got %h expected aa223344", rd);
        else passed++;
        do_xfer(0, 32'h14, 1'b0, 3'd2, 32'h0, rd, w, rs, fr);
        checks++;
        if (rd !== 32'hBEEF7788) $display("FAIL half_write: got %h expected beef7788", rd);
        else passed++;
        do_xfer(0, 32'h11, 1'b1, 3'd0, 32'h00005500, rd, w, rs, fr);
        do_xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, w, rs, fr);
        checks++;
        if (rd !== 32'hAA225544) $display("FAIL byte_lane1: got %h expected aa225544", rd);
        else passed++;
    endtask

    // IDLE, unselected NONSEQ and BUSY cycles: OKAY, ready, no write
    task automatic test_idle_unselected();
        logic        sel_v [3];
        logic [1:0]  trn_v [3];
        logic [31:0] rd;
        int w;
        logic rs, fr;
        sel_v[0] = 1'b1; trn_v[0] = 2'd0;
        sel_v[1] = 1'b0; trn_v[1] = 2'd2;
        sel_v[2] = 1'b1; trn_v[2] = 2'd1;
        for (int p = 0; p < 3; p++) begin
            hsel[0] = sel_v[p]; htrans[0] = trn_v[p]; haddr[0] = 32'h10;
            hwrite[0] = 1'b1; hsize[0] = 3'd2;
            @(posedge clk); #1;
            drive_idle(0);
            hwdata[0] = 32'hFFFFFFFF;
            @(negedge clk);
            checks++;
            if (hreadyout[0] !== 1'b1 || hresp[0] !== 1'b0)
                $display("FAIL idle_resp[%0d]: hreadyout %b hresp %b expected 1 0", p, hreadyout[0], hresp[0]);
            else passed++;
            @(posedge clk); #1;
        end
        do_xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, w, rs, fr);
        checks++;
        if (rd !== 32'hAA225544) $display("FAIL idle_no_write: got %h expected aa225544", rd);
        else passed++;
    endtask

    task automatic test_error();
        logic [31:0] rd;
        int w;
        logic rs, fr;
        do_xfer(0, 32'h0, 1'b1, 3'd2, 32'h12345678, rd, w, rs, fr);
`ifdef AHB5_SLV_ERR_EN
        do_xfer(0, 32'h1000, 1'b1, 3'd2, 32'hCAFEF00D, rd, w, rs, fr);
        checks++;
        if (fr !== 1'b1 || w !== 1 || rs !== 1'b1)
            $display("FAIL err_range: first_resp %b waits %0d resp %b expected 1 1 1", fr, w, rs);
        else passed++;
        do_xfer(0, 32'h2, 1'b0, 3'd2, 32'h0, rd, w, rs, fr);
        checks++;
        if (fr !== 1'b1 || w !== 1 || rs !== 1'b1)
            $display("FAIL err_align: first_resp %b waits %0d resp %b expected 1 1 1", fr, w, rs);
        else passed++;
        do_xfer(0, 32'h0, 1'b0, 3'd2, 32'h0, rd, w, rs, fr);
        checks++;
        if (rd !== 32'h12345678 || w !== 0 || rs !== 1'b0)
            $display("FAIL err_no_write: data %h waits %0d resp %b expected 12345678 0 0", rd, w, rs);
        else passed++;
`else
        do_xfer(0, 32'h1000, 1'b1, 3'd2, 32'hCAFEF00D, rd, w, rs, fr);
        checks++;
        if (fr !== 1'b0 || w !== 0 || rs !== 1'b0)
            $display("FAIL wrap_resp: first_resp %b waits %0d resp %b expected 0 0 0", fr, w, rs);
        else passed++;
        do_xfer(0, 32'h0, 1'b0, 3'd2, 32'h0, rd, w, rs, fr);
        checks++;
        if (rd !== 32'hCAFEF00D) $display("FAIL wrap_addr: got %h expected cafef00d", rd);
        else passed++;
        do_xfer(0, 32'h0, 1'b0, 3'd3, 32'h0, rd, w, rs, fr);
        checks++;
        if (rd !== 32'hCAFEF00D || rs !== 1'b0)
            $display("FAIL size3_word: data %h resp %b expected cafef00d 0", rd, rs);
        else passed++;
`endif
    endtask

    // INCR4 write burst with two wait states per beat, pipelined SEQ beats
    task automatic test_back_to_back();
        logic [31:0] bdata [4];
        logic [31:0] nxt_addr;
        logic [1:0]  nxt_trans;
        logic [31:0] rd;
        int waits;
        int n;
        logic rs, fr;
        bdata[0] = 32'hA0A0A0A0; bdata[1] = 32'hB1B1B1B1;
        bdata[2] = 32'hC2C2C2C2; bdata[3] = 32'hD3D3D3D3;
        hsel[1] = 1'b1; htrans[1] = 2'd2; haddr[1] = 32'h20; hwrite[1] = 1'b1;
        hsize[1] = 3'd2; hburst[1] = 3'b011;
        n = 0;
        @(negedge clk);
        while (!hreadyout[1] && n < 64) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) begin
            hwdata[1] = bdata[b];
            nxt_addr  = 32'h20 + 32'(4 * (b + 1));
            nxt_trans = (b < 3) ? 2'd3 : 2'd0;
            haddr[1]  = nxt_addr;
            htrans[1] = nxt_trans;
            waits = 0;
            @(negedge clk);
            while (!hreadyout[1] && waits < 64) begin
                waits++;
                // Scramble the address phase while stalled; the slave must ignore it
                haddr[1]  = 32'h300;
                htrans[1] = 2'd2;
                @(posedge clk); #1;
                haddr[1]  = nxt_addr;
                htrans[1] = nxt_trans;
                @(negedge clk);
            end
            checks++;
            if (waits !== 2) $display("FAIL burst_waits[%0d]: got %0d expected 2", b, waits);
            else passed++;
            @(posedge clk); #1;
        end
        drive_idle(1);
        for (int b = 0; b < 4; b++) begin
            do_xfer(1, 32'h20 + 32'(4 * b), 1'b0, 3'd2, 32'h0, rd, waits, rs, fr);
            checks++;
            if (rd !== bdata[b] || waits !== 2)
                $display("FAIL burst_read[%0d]: data %h waits %0d expected %h 2", b, rd, waits, bdata[b]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int w;
        logic rs, fr;
        do_xfer(1, 32'h40, 1'b1, 3'd2, 32'h01020304, rd, w, rs, fr);
        hsel[1] = 1'b1; htrans[1] = 2'd2; haddr[1] = 32'h40; hwrite[1] = 1'b1; hsize[1] = 3'd2;
        @(posedge clk); #1;
        drive_idle(1);
        hwdata[1] = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if (hreadyout[1] !== 1'b0) $display("FAIL mid_in_wait: hreadyout %b expected 0", hreadyout[1]);
        else passed++;
        hresetn[1] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (hreadyout[1] !== 1'b1 || hresp[1] !== 1'b0)
            $display("FAIL mid_reset_resp: hreadyout %b hresp %b expected 1 0", hreadyout[1], hresp[1]);
        else passed++;
        hresetn[1] = 1'b1;
        @(posedge clk); #1;
        do_xfer(1, 32'h40, 1'b0, 3'd2, 32'h0, rd, w, rs, fr);
        checks++;
        if (rd !== 32'h01020304 || w !== 2)
            $display("FAIL mid_reset_mem: data %h waits %0d expected 01020304 2", rd, w);
        else passed++;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            hresetn[d] = 1'b0;
            hwdata[d]  = 32'h0;
            drive_idle(d);
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        hresetn[0] = 1'b1;
        hresetn[1] = 1'b1;
        @(posedge clk); #1;
        test_write_read();
        test_byte_lanes();
        test_idle_unselected();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
